ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Arbiter that shares the single synchronous port A of the main RAM among three requesters: data access (MEM stage load/store), instruction fetch, and a DMA/loader master. Each cycle it grants at most one request, drives the RAM address/data/byte-enable/write-enable, and tags each read so that the returned word goes back to the correct requester after the RAM read latency. It replaces the current fixed fetch/data address mux and adds starvation protection for the DMA master.

## Interface
Parameters:
- RD_LAT, 1, RAM read latency in cycles from the granting edge to valid `ram_q`; legal values are 1 or 2.
- STARVE_LIMIT, 8, number of consecutive denied DMA cycles before the DMA master is promoted to top priority; legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- d_req, f_req, m_req  in  1 each  request from data, fetch and DMA; held until granted.
- d_addr, f_addr, m_addr  in  32 each  byte address.
- d_we, m_we  in  1 each  write request. Fetch is read-only.
- d_wdata, m_wdata  in  32 each  write data, already lane-aligned.
- d_byteen, m_byteen  in  4 each  write byte enables; bit 3 is the MSB lane.
- d_gnt, f_gnt, m_gnt  out  1 each  request accepted this cycle (combinational).
- rvalid  out  1  read data valid on `rdata` this cycle.
- rid  out  2  owner of `rdata`: 0 = data, 1 = fetch, 2 = DMA.
- rdata  out  32  read word (`ram_q` passed through).
- ram_addr  out  30  word address, equal to the winner's addr[31:2].
- ram_wdata  out  32  write data.
- ram_byteen  out  4  byte enables.
- ram_wren  out  1  write strobe.
- ram_q  in  32  RAM read data.
- starve_active  out  1  DMA promotion flag.

## Operation
- Arbitration is combinational each cycle, over the requests present in that cycle.
- Normal priority order: data, then fetch, then DMA.
- When `starve_active` = 1, the order is DMA, then data, then fetch.
- Exactly one `*_gnt` is high when any request is high. All grants are 0 otherwise.
- RAM port driving:
  - `ram_*` signals follow the winner.
  - With no winner: `ram_wren` = 0, `ram_byteen` = 4'b1111, and `ram_addr`/`ram_wdata` hold the data requester's values. These are don't-care for verification.
  - On a read grant, `ram_byteen` = 4'b1111 regardless of the requester's `byteen`.
  - On a write grant, `ram_byteen` = the requester's `byteen` and `ram_wren` = 1.
- Read tagging:
  - A granted read pushes {valid = 1, id} into a RD_LAT-deep tag shift register.
  - A write or idle cycle pushes valid = 0.
  - The tail of the shift register drives `rvalid`/`rid`.
- Starvation counter (8 bits):
  - Increments (saturating at STARVE_LIMIT) each cycle in which `m_req` = 1 and `m_gnt` = 0.
  - Clears in any cycle with `m_gnt` = 1 or `m_req` = 0.
  - `starve_active` is a register, set when the counter reaches STARVE_LIMIT and cleared on the cycle after `m_gnt`.
- Requesters must not change `addr`/`we`/`wdata`/`byteen` while `req` is high and not yet granted. A request dropped before grant is legal and is simply not served.
- Multiple outstanding reads are allowed: one per cycle, fully pipelined, no back-pressure on the return path.

## Timing
- Grant latency is 0 cycles. `*_gnt` is valid in the same cycle as `req`, and the RAM samples on the next rising edge.
- A read granted in cycle N produces `rvalid` = 1, the corresponding `rid`, and valid `rdata` in cycle N+RD_LAT.
- Writes complete at the edge ending the grant cycle. A read of the same address granted in cycle N+1 returns the new data.
- Back-to-back grants to different requesters in consecutive cycles are allowed, and their returns appear in consecutive cycles in grant order.
- Reset values:
  - `rvalid` = 0, `rid` = 0, `starve_active` = 0, counter = 0, and all tag stages invalid.
  - Combinational outputs follow their inputs even during reset, except that all `*_gnt` = 0 and `ram_wren` = 0 while reset is high.
- Reset mid-operation: outstanding reads are discarded and no `rvalid` is asserted for them. After deassertion, the first grant is possible in the first cycle.
- Simultaneous promotion: if the counter reaches STARVE_LIMIT in the same cycle a data request arrives, the promotion takes effect in the following cycle.
- `m_req` deasserted while `starve_active` = 1 clears `starve_active` on the next edge.

## Test plan
- Single fetch read: `f_req`/`f_addr` = 0x0000_0010 with `ram_q` modelling memory word 4 = 0x1234_5678 -> `f_gnt` = 1 in the same cycle, `ram_addr` = 4, `ram_byteen` = 4'hF, then 1 cycle later `rvalid` = 1, `rid` = 1, `rdata` = 0x1234_5678.
- Collision: `d_req` read @0x20 and `f_req` @0x24 in the same cycle -> `d_gnt` first, `f_gnt` the next cycle, returns with `rid` = 0 then `rid` = 1 in consecutive cycles.
- Byte store: `d_we` = 1, `d_byteen` = 4'b0010, `d_wdata` = 0x0000_AB00 @0x103 -> `ram_wren` = 1, `ram_byteen` = 4'b0010, `ram_addr` = 0x40, no `rvalid`. A following read returns only byte lane 1 changed.
- Starvation: `d_req` and `m_req` held high continuously with STARVE_LIMIT = 8 -> `starve_active` rises after 8 denied cycles, `m_gnt` is given the next cycle, then `starve_active` clears and data wins again.
- Reset mid-flight (RD_LAT = 2): grant two reads, assert `reset` one cycle later -> no `rvalid`, `starve_active` = 0, and a fresh request is granted in the first cycle after deassertion.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Shares RAM port A among data, fetch and DMA requesters with a DMA starvation guard.
// Read returns are tagged with their owner through an RD_LAT-deep shift register.
module ram_port_arbiter #(
  parameter int RD_LAT       = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        d_req,
  input  logic        f_req,
  input  logic        m_req,
  input  logic [31:0] d_addr,
  input  logic [31:0] f_addr,
  input  logic [31:0] m_addr,
  input  logic        d_we,
  input  logic        m_we,
  input  logic [31:0] d_wdata,
  input  logic [31:0] m_wdata,
  input  logic [3:0]  d_byteen,
  input  logic [3:0]  m_byteen,
  output logic        d_gnt,
  output logic        f_gnt,
  output logic        m_gnt,
  output logic        rvalid,
  output logic [1:0]  rid,
  output logic [31:0] rdata,
  output logic [29:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic [3:0]  ram_byteen,
  output logic        ram_wren,
  input  logic [31:0] ram_q,
  output logic        starve_active
);

  typedef enum logic [1:0] {
    OWN_D = 2'd0,
    OWN_F = 2'd1,
    OWN_M = 2'd2
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e id;
  } tag_t;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [7:0] starve_cnt;
  logic [7:0] starve_cnt_d;
  logic       starve_d;
  tag_t       tag_in;
  tag_t       tag_q [RD_LAT];

  // Byte-offset bits never reach the word-addressed RAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{d_addr[1:0], f_addr[1:0], m_addr[1:0]};

  // Grants are forced low during reset so nothing is written to the RAM.
  always_comb begin
    d_gnt = 1'b0;
    f_gnt = 1'b0;
    m_gnt = 1'b0;
    if (!reset) begin
      if (starve_active && m_req) m_gnt = 1'b1;
      else if (d_req)             d_gnt = 1'b1;
      else if (f_req)             f_gnt = 1'b1;
      else if (m_req)             m_gnt = 1'b1;
    end
  end

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    ram_addr   = d_addr[31:2];
    ram_wdata  = d_wdata;
    ram_byteen = 4'hF;
    ram_wren   = 1'b0;
    if (f_gnt) begin
      ram_addr = f_addr[31:2];
    end else if (m_gnt) begin
      ram_addr  = m_addr[31:2];
      ram_wdata = m_wdata;
      if (m_we) begin
        ram_byteen = m_byteen;
        ram_wren   = 1'b1;
      end
    end else if (d_gnt && d_we) begin
      ram_byteen = d_byteen;
      ram_wren   = 1'b1;
    end
  end

  always_comb begin
    tag_in.valid = (d_gnt && !d_we) || f_gnt || (m_gnt && !m_we);
    tag_in.id    = f_gnt ? OWN_F : (m_gnt ? OWN_M : OWN_D);
  end

  // NOTE: the tag pipe is reset (unlike RAM storage) because its valid bits drive rvalid;
  // this is also what discards in-flight reads on a mid-operation reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_q <= '{default: '0};
    end else begin
      tag_q[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign rvalid = tag_q[RD_LAT-1].valid;
  assign rid    = tag_q[RD_LAT-1].id;
  assign rdata  = ram_q;

  // Promotion is registered, so a limit reached this cycle only reorders next cycle.
  always_comb begin
    starve_cnt_d = '0;
    starve_d     = 1'b0;
    if (m_req && !m_gnt) begin
      starve_cnt_d = (starve_cnt >= LIMIT) ? LIMIT : starve_cnt + 8'd1;
      starve_d     = starve_active || (starve_cnt_d == LIMIT);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt    <= '0;
      starve_active <= 1'b0;
    end else begin
      starve_cnt    <= starve_cnt_d;
      starve_active <= starve_d;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: RD_LAT=1 and RD_LAT=2 instances share stimulus,
// each with its own RAM model; read returns are matched against a scoreboard.
module tb_ram_port_arbiter;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        d_req, f_req, m_req, d_we, m_we;
  logic [31:0] d_addr, f_addr, m_addr, d_wdata, m_wdata;
  logic [3:0]  d_byteen, m_byteen;

  logic        d_gnt1, f_gnt1, m_gnt1, rvalid1, ram_wren1, starve1;
  logic [1:0]  rid1;
  logic [31:0] rdata1, ram_wdata1, q1;
  logic [29:0] ram_addr1;
  logic [3:0]  ram_byteen1;

  logic        d_gnt2, f_gnt2, m_gnt2, rvalid2, ram_wren2, starve2;
  logic [1:0]  rid2;
  logic [31:0] rdata2, ram_wdata2, q2, p2;
  logic [29:0] ram_addr2;
  logic [3:0]  ram_byteen2;

  logic [31:0] mem1 [256];
  logic [31:0] mem2 [256];
  bit          wr1 [256];
  bit          wr2 [256];
  logic [31:0] ref_mem [256];

  exp_t q_exp1 [$];
  exp_t q_exp2 [$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  wire unused_tb = ^{ram_addr1[29:8], ram_addr2[29:8]};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_port_arbiter #(.RD_LAT(1), .STARVE_LIMIT(8)) u_dut1 (
    .clk(clk), .reset(reset),
    .d_req(d_req), .f_req(f_req), .m_req(m_req),
    .d_addr(d_addr), .f_addr(f_addr), .m_addr(m_addr),
    .d_we(d_we), .m_we(m_we), .d_wdata(d_wdata), .m_wdata(m_wdata),
    .d_byteen(d_byteen), .m_byteen(m_byteen),
    .d_gnt(d_gnt1), .f_gnt(f_gnt1), .m_gnt(m_gnt1),
    .rvalid(rvalid1), .rid(rid1), .rdata(rdata1),
    .ram_addr(ram_addr1), .ram_wdata(ram_wdata1), .ram_byteen(ram_byteen1),
    .ram_wren(ram_wren1), .ram_q(q1), .starve_active(starve1)
  );

  ram_port_arbiter #(.RD_LAT(2), .STARVE_LIMIT(8)) u_dut2 (
    .clk(clk), .reset(reset),
    .d_req(d_req), .f_req(f_req), .m_req(m_req),
    .d_addr(d_addr), .f_addr(f_addr), .m_addr(m_addr),
    .d_we(d_we), .m_we(m_we), .d_wdata(d_wdata), .m_wdata(m_wdata),
    .d_byteen(d_byteen), .m_byteen(m_byteen),
    .d_gnt(d_gnt2), .f_gnt(f_gnt2), .m_gnt(m_gnt2),
    .rvalid(rvalid2), .rid(rid2), .rdata(rdata2),
    .ram_addr(ram_addr2), .ram_wdata(ram_wdata2), .ram_byteen(ram_byteen2),
    .ram_wren(ram_wren2), .ram_q(q2), .starve_active(starve2)
  );

  function automatic logic [31:0] init_word(input logic [7:0] a);
    return (a == 8'd4) ? 32'h1234_5678 : {a, ~a, a ^ 8'h3C, 8'h5A};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Synchronous RAM models: latency 1 for u_dut1, latency 2 for u_dut2.
  always @(posedge clk) begin
    if (ram_wren1) begin
      mem1[ram_addr1[7:0]] <= merge(wr1[ram_addr1[7:0]] ? mem1[ram_addr1[7:0]] : init_word(ram_addr1[7:0]),
                                    ram_wdata1, ram_byteen1);
      wr1[ram_addr1[7:0]]  <= 1'b1;
    end
    q1 <= wr1[ram_addr1[7:0]] ? mem1[ram_addr1[7:0]] : init_word(ram_addr1[7:0]);
  end

  always @(posedge clk) begin
    if (ram_wren2) begin
      mem2[ram_addr2[7:0]] <= merge(wr2[ram_addr2[7:0]] ? mem2[ram_addr2[7:0]] : init_word(ram_addr2[7:0]),
                                    ram_wdata2, ram_byteen2);
      wr2[ram_addr2[7:0]]  <= 1'b1;
    end
    p2 <= wr2[ram_addr2[7:0]] ? mem2[ram_addr2[7:0]] : init_word(ram_addr2[7:0]);
    q2 <= p2;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mon_port(input int p, input logic rv, input logic [1:0] id, input logic [31:0] d);
    exp_t e;
    bit   have;
    have = (p == 1) ? (q_exp1.size() > 0) : (q_exp2.size() > 0);
    if (have) begin
      if (p == 1) e = q_exp1[0];
      else        e = q_exp2[0];
    end
    if (rv) begin
      if (!have) begin
        check($sformatf("p%0d_unexpected_rvalid", p), 32'(rv), 32'd0);
      end else begin
        if (p == 1) void'(q_exp1.pop_front());
        else        void'(q_exp2.pop_front());
        check($sformatf("p%0d_rid", p), 32'(id), 32'(e.id));
        check($sformatf("p%0d_rdata", p), d, e.data);
        check($sformatf("p%0d_ret_cycle", p), 32'(cyc), 32'(e.due));
      end
    end else if (have && e.due <= cyc) begin
      check($sformatf("p%0d_missing_rvalid", p), 32'(rv), 32'd1);
      if (p == 1) void'(q_exp1.pop_front());
      else        void'(q_exp2.pop_front());
    end
  endtask

  always @(negedge clk) begin
    mon_port(1, rvalid1, rid1, rdata1);
    mon_port(2, rvalid2, rid2, rdata2);
  end

  task automatic rd_push(input logic [1:0] id, input logic [31:0] addr, input bit to1, input bit to2);
    exp_t e;
    e.id   = id;
    e.data = ref_mem[addr[9:2]];
    e.due  = cyc + 1;
    if (to1) q_exp1.push_back(e);
    e.due  = cyc + 2;
    if (to2) q_exp2.push_back(e);
  endtask

  task automatic chk_gnt(input string tag, input logic [2:0] exp);
    check({tag, "_gnt1"}, {29'd0, d_gnt1, f_gnt1, m_gnt1}, {29'd0, exp});
    check({tag, "_gnt2"}, {29'd0, d_gnt2, f_gnt2, m_gnt2}, {29'd0, exp});
  endtask

  task automatic chk_starve(input string tag, input logic exp);
    check({tag, "_starve1"}, 32'(starve1), 32'(exp));
    check({tag, "_starve2"}, 32'(starve2), 32'(exp));
  endtask

  task automatic idle();
    d_req = 1'b0; f_req = 1'b0; m_req = 1'b0; d_we = 1'b0; m_we = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(8'(i));
    idle();
    d_addr = '0; f_addr = '0; m_addr = '0; d_wdata = '0; m_wdata = '0;
    d_byteen = 4'hF; m_byteen = 4'hF;
    #1 reset = 1'b1;

    // Reset: registered outputs cleared, grants and write strobe suppressed.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200;
    @(negedge clk);
    chk_gnt("rst", 3'b000);
    check("rst_wren1", 32'(ram_wren1), 32'd0);
    check("rst_rvalid1", 32'(rvalid1), 32'd0);
    check("rst_rid1", 32'(rid1), 32'd0);
    chk_starve("rst", 1'b0);
    tick();
    reset = 1'b0;
    idle();

    // Single fetch read of word 4.
    f_req = 1'b1; f_addr = 32'h10;
    @(negedge clk);
    chk_gnt("fetch", 3'b010);
    check("fetch_addr", 32'(ram_addr1), 32'h4);
    check("fetch_byteen", 32'(ram_byteen1), 32'hF);
    check("fetch_wren", 32'(ram_wren1), 32'd0);
    rd_push(2'd1, f_addr, 1'b1, 1'b1);
    tick();
    idle();

    // Data/fetch collision: data first, fetch next cycle.
    d_req = 1'b1; d_addr = 32'h20; d_byteen = 4'b0001;
    f_req = 1'b1; f_addr = 32'h24;
    @(negedge clk);
    chk_gnt("coll_a", 3'b100);
    check("coll_a_addr", 32'(ram_addr1), 32'h8);
    check("coll_a_byteen", 32'(ram_byteen1), 32'hF);
    rd_push(2'd0, d_addr, 1'b1, 1'b1);
    tick();
    d_req = 1'b0;
    @(negedge clk);
    chk_gnt("coll_b", 3'b010);
    check("coll_b_addr", 32'(ram_addr1), 32'h9);
    rd_push(2'd1, f_addr, 1'b1, 1'b1);
    tick();
    idle();

    // Byte store to lane 1 then readback.
    d_req = 1'b1; d_we = 1'b1; d_byteen = 4'b0010; d_wdata = 32'h0000_AB00; d_addr = 32'h103;
    @(negedge clk);
    chk_gnt("bst", 3'b100);
    check("bst_wren", 32'(ram_wren1), 32'd1);
    check("bst_byteen", 32'(ram_byteen1), 32'h2);
    check("bst_addr", 32'(ram_addr1), 32'h40);
    check("bst_wdata", ram_wdata1, 32'h0000_AB00);
    ref_mem[8'h40] = merge(ref_mem[8'h40], d_wdata, d_byteen);
    tick();
    d_we = 1'b0; d_byteen = 4'hF; d_addr = 32'h100;
    @(negedge clk);
    chk_gnt("bst_rd", 3'b100);
    rd_push(2'd0, d_addr, 1'b1, 1'b1);
    tick();
    idle();

    // DMA partial write then DMA readback.
    m_req = 1'b1; m_we = 1'b1; m_byteen = 4'b1100; m_wdata = 32'hDEAD_BEEF; m_addr = 32'h50;
    @(negedge clk);
    chk_gnt("mwr", 3'b001);
    check("mwr_wren", 32'(ram_wren1), 32'd1);
    check("mwr_byteen", 32'(ram_byteen1), 32'hC);
    check("mwr_addr", 32'(ram_addr1), 32'h14);
    check("mwr_wdata", ram_wdata1, 32'hDEAD_BEEF);
    ref_mem[8'h14] = merge(ref_mem[8'h14], m_wdata, m_byteen);
    tick();
    m_we = 1'b0;
    @(negedge clk);
    chk_gnt("mrd", 3'b001);
    check("mrd_byteen", 32'(ram_byteen1), 32'hF);
    rd_push(2'd2, m_addr, 1'b1, 1'b1);
    tick();
    idle();

    // Three-way read contention resolves data, fetch, DMA.
    d_req = 1'b1; d_addr = 32'h30; f_req = 1'b1; f_addr = 32'h34; m_req = 1'b1; m_addr = 32'h38;
    @(negedge clk);
    chk_gnt("tri_a", 3'b100);
    rd_push(2'd0, d_addr, 1'b1, 1'b1);
    tick();
    d_req = 1'b0;
    @(negedge clk);
    chk_gnt("tri_b", 3'b010);
    rd_push(2'd1, f_addr, 1'b1, 1'b1);
    tick();
    f_req = 1'b0;
    @(negedge clk);
    chk_gnt("tri_c", 3'b001);
    check("tri_c_addr", 32'(ram_addr1), 32'hE);
    rd_push(2'd2, m_addr, 1'b1, 1'b1);
    tick();
    idle();
    tick();

    // Starvation: eight denied cycles, one promoted DMA grant, then data again.
    d_req = 1'b1; d_addr = 32'h60; m_req = 1'b1; m_addr = 32'h64;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk_gnt($sformatf("stv_deny%0d", k), 3'b100);
      chk_starve($sformatf("stv_deny%0d", k), 1'b0);
      rd_push(2'd0, d_addr, 1'b1, 1'b1);
      tick();
    end
    @(negedge clk);
    chk_gnt("stv_promo", 3'b001);
    chk_starve("stv_promo", 1'b1);
    rd_push(2'd2, m_addr, 1'b1, 1'b1);
    tick();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk_gnt($sformatf("stv_again%0d", k), 3'b100);
      chk_starve($sformatf("stv_again%0d", k), 1'b0);
      rd_push(2'd0, d_addr, 1'b1, 1'b1);
      tick();
    end
    // Promotion pending but DMA withdraws: data wins, flag drops next edge.
    m_req = 1'b0;
    @(negedge clk);
    chk_starve("stv_drop", 1'b1);
    chk_gnt("stv_drop", 3'b100);
    rd_push(2'd0, d_addr, 1'b1, 1'b1);
    tick();
    @(negedge clk);
    chk_starve("stv_clear", 1'b0);
    chk_gnt("stv_clear", 3'b100);
    rd_push(2'd0, d_addr, 1'b1, 1'b1);
    tick();
    idle();

    // Reset mid-flight: two reads granted, reset flushes whatever is still in flight.
    d_req = 1'b1; d_addr = 32'h20;
    @(negedge clk);
    chk_gnt("rmf_a", 3'b100);
    rd_push(2'd0, d_addr, 1'b1, 1'b0);
    tick();
    d_req = 1'b0; f_req = 1'b1; f_addr = 32'h24;
    @(negedge clk);
    chk_gnt("rmf_b", 3'b010);
    tick();
    reset = 1'b1;
    idle();
    @(negedge clk);
    check("rmf_rvalid1", 32'(rvalid1), 32'd0);
    check("rmf_rvalid2", 32'(rvalid2), 32'd0);
    check("rmf_rid2", 32'(rid2), 32'd0);
    chk_starve("rmf", 1'b0);
    tick();
    @(negedge clk);
    check("rmf_hold_rvalid2", 32'(rvalid2), 32'd0);
    tick();
    reset = 1'b0;
    f_req = 1'b1; f_addr = 32'h10;
    @(negedge clk);
    chk_gnt("rmf_first", 3'b010);
    rd_push(2'd1, f_addr, 1'b1, 1'b1);
    tick();
    idle();
    repeat (4) tick();

    check("drain_q1", 32'(q_exp1.size()), 32'd0);
    check("drain_q2", 32'(q_exp2.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
